tb_pzcorebus_request_arbiter: RTL and testbench

- Testbench-side N:1 corebus arbiter that lets several master agents share one slave BFM (RAM model or VIP slave).
- Performs round-robin command arbitration and keeps write data in command order.
- Tags each request's mid with the source port index, and routes responses back to the source port by decoding sid.
- Sits between the master BFMs/DUT ports and tb_pzcorebus_slave_bfm.

---
 rtl/tb_pzcorebus_request_arbiter_pkg.sv | 63 ++++++
 rtl/tb_pzcorebus_request_arbiter_if.sv | 37 +++
 rtl/tb_pzcorebus_arbiter_index_fifo.sv | 58 +++++
 rtl/tb_pzcorebus_request_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tb_pzcorebus_request_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tb_pzcorebus_request_arbiter_pkg.sv
// Shared corebus types and arbiter tag helpers.
// The port tag lives in the top bits of mid/sid.
package pztb_pkg;
   localparam int ID_WIDTH      = 8;
   localparam int ADDR_WIDTH    = 16;
   localparam int DATA_WIDTH    = 32;
   localparam int LENGTH_WIDTH  = 4;
   localparam int MAX_TAG_WIDTH = 4;

   typedef enum logic [1:0] {
      CMD_READ     = 2'd0,
      CMD_WRITE    = 2'd1,
      CMD_WRITE_NP = 2'd2
   } pzcorebus_command_type;

   typedef struct packed {
      logic csr_profile;
   } pzcorebus_config;

   typedef logic [ID_WIDTH-1:0] pzcorebus_id;

   function automatic int calc_arbiter_index_width(int num_masters);
      return (num_masters <= 1) ? 1 : $clog2(num_masters);
   endfunction

   function automatic logic is_command_with_data(
      pzcorebus_command_type c
   );
      return (c == CMD_WRITE) || (c == CMD_WRITE_NP);
   endfunction

   function automatic pzcorebus_id insert_tag(
      pzcorebus_id              id,
      logic [MAX_TAG_WIDTH-1:0] tag,
      int                       width
   );
      pzcorebus_id r;
      r = id;
      for (int j = 0; j < MAX_TAG_WIDTH; j++) begin
         if (j < width) r[ID_WIDTH-width+j] = tag[j];
      end
      return r;
   endfunction

   function automatic pzcorebus_id clear_tag(
      pzcorebus_id id,
      int          width
   );
      return insert_tag(id, '0, width);
   endfunction

   function automatic logic [MAX_TAG_WIDTH-1:0] get_tag(
      pzcorebus_id id,
      int          width
   );
      logic [MAX_TAG_WIDTH-1:0] t;
      t = '0;
      for (int j = 0; j < MAX_TAG_WIDTH; j++) begin
         if (j < width) t[j] = id[ID_WIDTH-width+j];
      end
      return t;
   endfunction
endpackage

// File: rtl/tb_pzcorebus_request_arbiter_if.sv
// Corebus command/data/response channel bundle.
// master drives commands and data; slave drives responses.
interface pzcorebus_if;
   import pztb_pkg::*;

   logic                       mcmd_valid;
   logic                       scmd_accept;
   pzcorebus_command_type      mcmd;
   pzcorebus_id                mid;
   logic [ADDR_WIDTH-1:0]      maddr;
   logic [LENGTH_WIDTH-1:0]    mlength;
   logic                       mdata_valid;
   logic                       sdata_accept;
   logic [DATA_WIDTH-1:0]      mdata;
   logic                       mdata_last;
   logic                       sresp_valid;
   logic                       mresp_accept;
   pzcorebus_id                sid;
   logic [DATA_WIDTH-1:0]      sdata;
   logic                       sresp_last;

   modport master (
      output mcmd_valid, mcmd, mid, maddr, mlength,
      output mdata_valid, mdata, mdata_last,
      output mresp_accept,
      input  scmd_accept, sdata_accept,
      input  sresp_valid, sid, sdata, sresp_last
   );

   modport slave (
      input  mcmd_valid, mcmd, mid, maddr, mlength,
      input  mdata_valid, mdata, mdata_last,
      input  mresp_accept,
      output scmd_accept, sdata_accept,
      output sresp_valid, sid, sdata, sresp_last
   );
endinterface

// File: rtl/tb_pzcorebus_arbiter_index_fifo.sv
// Flop FIFO of grant indices, one entry per write
// command still owed its data burst.
module tb_pzcorebus_arbiter_index_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   function automatic logic [PW-1:0] next_ptr(
      logic [PW-1:0] p
   );
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_d  = push_i ? next_ptr(wr_q) : wr_q;
      rd_d  = pop_i  ? next_ptr(rd_q) : rd_q;
      cnt_d = cnt_q;
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push_i) mem_q[wr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/tb_pzcorebus_request_arbiter.sv
// N:1 round-robin corebus arbiter for bench masters
// sharing one slave BFM; routes responses by sid tag.
module tb_pzcorebus_request_arbiter
   import pztb_pkg::*;
#(
   parameter pzcorebus_config BUS_CONFIG      = '0,
   parameter int              NUM_MASTERS     = 2,
   parameter int              INDEX_WIDTH     =
      calc_arbiter_index_width(NUM_MASTERS),
   parameter int              DATA_FIFO_DEPTH = 4,
   parameter bit              SVA_CHECKER     = 1
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   pzcorebus_if.slave  slave_if [NUM_MASTERS],
   pzcorebus_if.master master_if,
   output logic        o_unrouted_response
);
   localparam bit HAS_DATA = !BUS_CONFIG.csr_profile;
   typedef logic [INDEX_WIDTH-1:0] index_t;

   logic [NUM_MASTERS-1:0]  cmd_valid, cmd_with_data;
   logic [NUM_MASTERS-1:0]  eligible, rot;
   logic [NUM_MASTERS-1:0]  data_valid, data_last;
   logic [NUM_MASTERS-1:0]  resp_accept;
   pzcorebus_command_type   cmd_type [NUM_MASTERS];
   pzcorebus_id             cmd_id   [NUM_MASTERS];
   logic [ADDR_WIDTH-1:0]   cmd_addr [NUM_MASTERS];
   logic [LENGTH_WIDTH-1:0] cmd_len  [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]   data     [NUM_MASTERS];

   logic   lock_q, lock_d;
   index_t locked_q, locked_d;
   index_t rr_q, rr_d;
   index_t grant;
   logic   grant_found, grant_valid, cmd_ack;
   logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
   index_t fifo_head, data_sel;
   logic   data_sel_valid;
   index_t resp_idx;
   logic   resp_routed;
   logic   unrouted_q;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
      assign cmd_valid[i]     = slave_if[i].mcmd_valid;
      assign cmd_type[i]      = slave_if[i].mcmd;
      assign cmd_id[i]        = slave_if[i].mid;
      assign cmd_addr[i]      = slave_if[i].maddr;
      assign cmd_len[i]       = slave_if[i].mlength;
      assign cmd_with_data[i] = HAS_DATA &&
         is_command_with_data(slave_if[i].mcmd);
      assign data_valid[i]    = slave_if[i].mdata_valid;
      assign data[i]          = slave_if[i].mdata;
      assign data_last[i]     = slave_if[i].mdata_last;
      assign resp_accept[i]   = slave_if[i].mresp_accept;

      assign slave_if[i].scmd_accept =
         cmd_ack && (grant == index_t'(i));
      assign slave_if[i].sdata_accept =
         data_sel_valid && (data_sel == index_t'(i)) &&
         master_if.sdata_accept;
      assign slave_if[i].sresp_valid =
         i_rst_n && resp_routed && master_if.sresp_valid &&
         (resp_idx == index_t'(i));
      assign slave_if[i].sid =
         clear_tag(master_if.sid, INDEX_WIDTH);
      assign slave_if[i].sdata      = master_if.sdata;
      assign slave_if[i].sresp_last = master_if.sresp_last;

      if (SVA_CHECKER) begin : g_sva
         a_tag_zero: assert property (
            @(posedge i_clk) disable iff (!i_rst_n)
            slave_if[i].mcmd_valid |->
               get_tag(slave_if[i].mid, INDEX_WIDTH) == '0
         );
      end
   end

   // Full FIFO holds back new writes; reads keep flowing.
   assign eligible = cmd_valid &
      ~(fifo_full ? cmd_with_data : '0);
   assign rot = NUM_MASTERS'({eligible, eligible} >> rr_q);

   always_comb begin
      grant       = locked_q;
      grant_found = lock_q;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!grant_found && rot[k]) begin
            grant_found = 1'b1;
            grant = index_t'((int'(rr_q) + k) % NUM_MASTERS);
         end
      end
   end

   assign grant_valid = i_rst_n && grant_found &&
      cmd_valid[grant];
   assign cmd_ack = grant_valid && master_if.scmd_accept;

   assign master_if.mcmd_valid = grant_valid;
   assign master_if.mcmd       = cmd_type[grant];
   assign master_if.mid        = insert_tag(cmd_id[grant],
      MAX_TAG_WIDTH'(grant), INDEX_WIDTH);
   assign master_if.maddr      = cmd_addr[grant];
   assign master_if.mlength    = cmd_len[grant];

   always_comb begin
      lock_d   = lock_q;
      locked_d = locked_q;
      rr_d     = rr_q;
      if (cmd_ack) begin
         lock_d = 1'b0;
         rr_d   = (int'(grant) == NUM_MASTERS - 1) ?
            '0 : grant + 1'b1;
      end else if (grant_valid) begin
         lock_d   = 1'b1;
         locked_d = grant;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_q     <= 1'b0;
         locked_q   <= '0;
         rr_q       <= '0;
         unrouted_q <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         locked_q   <= locked_d;
         rr_q       <= rr_d;
         unrouted_q <= master_if.sresp_valid && !resp_routed;
      end
   end

   // An empty FIFO lets the just-granted writer send data at once.
   assign fifo_push = HAS_DATA && cmd_ack && cmd_with_data[grant];
   assign data_sel  = fifo_empty ? grant : fifo_head;
   assign data_sel_valid = i_rst_n && HAS_DATA &&
      (!fifo_empty || fifo_push);
   assign master_if.mdata_valid =
      data_sel_valid && data_valid[data_sel];
   assign master_if.mdata      = data[data_sel];
   assign master_if.mdata_last = data_last[data_sel];
   assign fifo_pop = master_if.mdata_valid &&
      master_if.sdata_accept && master_if.mdata_last;

   if (HAS_DATA) begin : g_fifo
      tb_pzcorebus_arbiter_index_fifo #(
         .WIDTH (INDEX_WIDTH),
         .DEPTH (DATA_FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (i_clk),
         .rst_ni  (i_rst_n),
         .push_i  (fifo_push),
         .data_i  (grant),
         .pop_i   (fifo_pop),
         .data_o  (fifo_head),
         .full_o  (fifo_full),
         .empty_o (fifo_empty)
      );
   end else begin : g_no_fifo
      assign fifo_head  = '0;
      assign fifo_full  = 1'b0;
      assign fifo_empty = 1'b1;
   end

   assign resp_idx = index_t'(get_tag(master_if.sid, INDEX_WIDTH));
   assign resp_routed = int'(resp_idx) < NUM_MASTERS;
   assign master_if.mresp_accept = i_rst_n &&
      (!resp_routed || resp_accept[resp_idx]);
   assign o_unrouted_response = unrouted_q;

   if (SVA_CHECKER) begin : g_sva_dn
      a_cmd_stable: assert property (
         @(posedge i_clk) disable iff (!i_rst_n)
         master_if.mcmd_valid && !master_if.scmd_accept |=>
            master_if.mcmd_valid && $stable(master_if.mid)
      );
   end
endmodule

// File: tb/tb_tb_pzcorebus_request_arbiter.sv
// Directed bench for the corebus request arbiter,
// three upstream ports and a two-deep write-data FIFO.
module tb_tb_pzcorebus_request_arbiter;
   import pztb_pkg::*;

   localparam int N = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pzcorebus_if up_if [N] ();
   pzcorebus_if dn_if ();

   logic [N-1:0]          m_valid, m_dvalid, m_dlast, m_raccept;
   pzcorebus_command_type m_cmd  [N];
   pzcorebus_id           m_id   [N];
   logic [DATA_WIDTH-1:0] m_data [N];
   logic [N-1:0]          s_caccept, s_daccept, s_rvalid;
   pzcorebus_id           s_sid  [N];
   logic                  unrouted;

   for (genvar g = 0; g < N; g++) begin : g_up
      assign up_if[g].mcmd_valid   = m_valid[g];
      assign up_if[g].mcmd         = m_cmd[g];
      assign up_if[g].mid          = m_id[g];
      assign up_if[g].maddr        = 16'(g);
      assign up_if[g].mlength      = 4'd1;
      assign up_if[g].mdata_valid  = m_dvalid[g];
      assign up_if[g].mdata        = m_data[g];
      assign up_if[g].mdata_last   = m_dlast[g];
      assign up_if[g].mresp_accept = m_raccept[g];
      assign s_caccept[g] = up_if[g].scmd_accept;
      assign s_daccept[g] = up_if[g].sdata_accept;
      assign s_rvalid[g]  = up_if[g].sresp_valid;
      assign s_sid[g]     = up_if[g].sid;
   end

   tb_pzcorebus_request_arbiter #(
      .BUS_CONFIG      ('0),
      .NUM_MASTERS     (N),
      .DATA_FIFO_DEPTH (2),
      .SVA_CHECKER     (1)
   ) u_dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .slave_if            (up_if),
      .master_if           (dn_if),
      .o_unrouted_response (unrouted)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_valid  = '0;
      m_dvalid = '0;
      m_dlast  = '0;
      for (int i = 0; i < N; i++) begin
         m_cmd[i]  = CMD_READ;
         m_id[i]   = '0;
         m_data[i] = '0;
      end
   endtask

   initial begin
      idle();
      m_raccept             = '1;
      dn_if.scmd_accept     = 1'b1;
      dn_if.sdata_accept    = 1'b1;
      dn_if.sresp_valid     = 1'b0;
      dn_if.sid             = '0;
      dn_if.sdata           = '0;
      dn_if.sresp_last      = 1'b1;
      m_valid               = '1;
      #1;
      check("rst_mcmd_valid", 64'(dn_if.mcmd_valid), 0);
      check("rst_mdata_valid", 64'(dn_if.mdata_valid), 0);
      check("rst_mresp_accept", 64'(dn_if.mresp_accept), 0);
      check("rst_scmd_accept", 64'(s_caccept), 0);
      check("rst_unrouted", 64'(unrouted), 0);
      step();
      idle();
      step();
      rst_n = 1'b1;

      // round robin: 3 ports x 4 reads
      for (int i = 0; i < N; i++) m_id[i] = pzcorebus_id'(i);
      m_valid = '1;
      for (int c = 0; c < 12; c++) begin
         int p, b;
         p = c % 3;
         b = c / 3;
         #1;
         check("rr_valid", 64'(dn_if.mcmd_valid), 1);
         check("rr_mid", 64'(dn_if.mid), 64'((p << 6) | (b << 4) | p));
         check("rr_accept", 64'(s_caccept), 64'(1 << p));
         step();
         m_id[p] = m_id[p] + 8'h10;
         if (b == 3) m_valid[p] = 1'b0;
      end
      for (int c = 0; c < 12; c++) begin
         int p, b;
         p = c % 3;
         b = c / 3;
         dn_if.sresp_valid = 1'b1;
         dn_if.sid = pzcorebus_id'((p << 6) | (b << 4) | p);
         #1;
         check("rr_resp_vld", 64'(s_rvalid), 64'(1 << p));
         check("rr_resp_sid", 64'(s_sid[p]), 64'((b << 4) | p));
         check("rr_resp_acc", 64'(dn_if.mresp_accept), 1);
         step();
      end
      m_raccept[1] = 1'b0;
      dn_if.sid = 8'h41;
      #1;
      check("resp_backpressure", 64'(dn_if.mresp_accept), 0);
      step();
      dn_if.sresp_valid = 1'b0;
      m_raccept = '1;

      // lock under backpressure
      dn_if.scmd_accept = 1'b0;
      m_cmd[1] = CMD_WRITE;
      m_id[1] = 8'h21;
      m_valid[1] = 1'b1;
      m_dvalid[1] = 1'b1;
      m_dlast[1] = 1'b1;
      m_data[1] = 32'hD1;
      #1;
      check("lock_first_mid", 64'(dn_if.mid), 64'h61);
      check("lock_data_early", 64'(dn_if.mdata_valid), 0);
      step();
      m_cmd[0] = CMD_READ;
      m_id[0] = 8'h02;
      m_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("lock_mid", 64'(dn_if.mid), 64'h61);
         check("lock_p0_acc", 64'(s_caccept[0]), 0);
         step();
      end
      dn_if.scmd_accept = 1'b1;
      #1;
      check("lock_p1_acc", 64'(s_caccept), 64'b010);
      check("bypass_valid", 64'(dn_if.mdata_valid), 1);
      check("bypass_data", 64'(dn_if.mdata), 64'hD1);
      check("bypass_dacc", 64'(s_daccept), 64'b010);
      step();
      m_valid[1] = 1'b0;
      m_dvalid[1] = 1'b0;
      #1;
      check("after_lock_mid", 64'(dn_if.mid), 64'h02);
      step();
      idle();

      // write ordering: p0 x4 then p1 x2, p1 data early
      m_cmd[0] = CMD_WRITE;
      m_id[0] = 8'h03;
      m_valid[0] = 1'b1;
      m_dvalid[1] = 1'b1;
      m_data[1] = 32'hB0;
      #1;
      check("ord_p0_mid", 64'(dn_if.mid), 64'h03);
      check("ord_p1_early", 64'(s_daccept[1]), 0);
      step();
      m_valid[0] = 1'b0;
      m_cmd[1] = CMD_WRITE;
      m_id[1] = 8'h04;
      m_valid[1] = 1'b1;
      #1;
      check("ord_p1_mid", 64'(dn_if.mid), 64'h44);
      check("ord_p1_hold", 64'(s_daccept[1]), 0);
      step();
      m_valid[1] = 1'b0;
      for (int b = 0; b < 4; b++) begin
         m_dvalid[0] = 1'b1;
         m_data[0] = 32'hA0 + 32'(b);
         m_dlast[0] = (b == 3);
         #1;
         check("ord_p0_data", 64'(dn_if.mdata), 64'(32'hA0 + 32'(b)));
         check("ord_dacc_p0", 64'(s_daccept), 64'b001);
         step();
      end
      m_dvalid[0] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_data[1] = 32'hB0 + 32'(b);
         m_dlast[1] = (b == 1);
         #1;
         check("ord_p1_data", 64'(dn_if.mdata), 64'(32'hB0 + 32'(b)));
         check("ord_dacc_p1", 64'(s_daccept), 64'b010);
         step();
      end
      idle();

      // FIFO full masks writes, reads still pass
      m_cmd[2] = CMD_WRITE;
      m_id[2] = 8'h05;
      m_valid[2] = 1'b1;
      #1;
      check("full_w1_mid", 64'(dn_if.mid), 64'h85);
      step();
      m_valid[2] = 1'b0;
      m_cmd[0] = CMD_WRITE;
      m_id[0] = 8'h06;
      m_valid[0] = 1'b1;
      #1;
      check("full_w2_mid", 64'(dn_if.mid), 64'h06);
      step();
      m_valid[0] = 1'b0;
      m_cmd[1] = CMD_WRITE;
      m_id[1] = 8'h07;
      m_valid[1] = 1'b1;
      #1;
      check("full_w3_masked", 64'(dn_if.mcmd_valid), 0);
      step();
      m_cmd[2] = CMD_READ;
      m_id[2] = 8'h08;
      m_valid[2] = 1'b1;
      #1;
      check("full_read_mid", 64'(dn_if.mid), 64'h88);
      check("full_w3_noacc", 64'(s_caccept), 64'b100);
      step();
      m_valid[2] = 1'b0;
      m_dvalid[2] = 1'b1;
      m_dlast[2] = 1'b1;
      m_data[2] = 32'hF2;
      #1;
      check("full_pop_dacc", 64'(s_daccept), 64'b100);
      check("full_still_masked", 64'(dn_if.mcmd_valid), 0);
      step();
      m_dvalid[2] = 1'b0;
      #1;
      check("full_w3_mid", 64'(dn_if.mid), 64'h47);
      step();
      m_valid[1] = 1'b0;
      m_dvalid[0] = 1'b1;
      m_dlast[0] = 1'b1;
      #1;
      check("full_drain_p0", 64'(s_daccept), 64'b001);
      step();
      m_dvalid[0] = 1'b0;
      m_dvalid[1] = 1'b1;
      m_dlast[1] = 1'b1;
      #1;
      check("full_drain_p1", 64'(s_daccept), 64'b010);
      step();
      idle();

      // unroutable response tag
      m_raccept = '0;
      dn_if.sresp_valid = 1'b1;
      dn_if.sid = 8'hC9;
      #1;
      check("bad_no_vld", 64'(s_rvalid), 0);
      check("bad_accept", 64'(dn_if.mresp_accept), 1);
      check("bad_pulse_pre", 64'(unrouted), 0);
      step();
      dn_if.sresp_valid = 1'b0;
      #1;
      check("bad_pulse", 64'(unrouted), 1);
      step();
      check("bad_pulse_end", 64'(unrouted), 0);
      m_raccept = '1;

      // reset in the middle of a write burst
      m_cmd[0] = CMD_WRITE;
      m_id[0] = 8'h09;
      m_valid[0] = 1'b1;
      #1;
      check("mr_cmd_mid", 64'(dn_if.mid), 64'h09);
      step();
      m_valid[0] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_dvalid[0] = 1'b1;
         m_data[0] = 32'hC0 + 32'(b);
         #1;
         check("mr_beat", 64'(dn_if.mdata), 64'(32'hC0 + 32'(b)));
         step();
      end
      m_data[0] = 32'hC2;
      m_cmd[1] = CMD_READ;
      m_id[1] = 8'h0A;
      m_valid[1] = 1'b1;
      dn_if.sresp_valid = 1'b1;
      dn_if.sid = 8'h00;
      rst_n = 1'b0;
      #1;
      check("mr_mcmd_valid", 64'(dn_if.mcmd_valid), 0);
      check("mr_mdata_valid", 64'(dn_if.mdata_valid), 0);
      check("mr_dacc", 64'(s_daccept), 0);
      check("mr_cacc", 64'(s_caccept), 0);
      check("mr_rvalid", 64'(s_rvalid), 0);
      check("mr_mresp_acc", 64'(dn_if.mresp_accept), 0);
      step();
      idle();
      dn_if.sresp_valid = 1'b0;
      rst_n = 1'b1;
      m_id[0] = 8'h0B;
      m_id[1] = 8'h0C;
      m_valid = 3'b011;
      #1;
      check("mr_rr_mid", 64'(dn_if.mid), 64'h0B);
      check("mr_rr_acc", 64'(s_caccept), 64'b001);
      step();
      idle();
      m_cmd[1] = CMD_WRITE;
      m_id[1] = 8'h0D;
      m_valid[1] = 1'b1;
      m_dvalid[1] = 1'b1;
      m_dlast[1] = 1'b1;
      m_data[1] = 32'hE0;
      #1;
      check("mr_empty_mid", 64'(dn_if.mid), 64'h4D);
      check("mr_empty_dvalid", 64'(dn_if.mdata_valid), 1);
      check("mr_empty_dacc", 64'(s_daccept), 64'b010);
      step();
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
